mem_responder_multi: RTL and testbench



---
 rtl/mem_responder_multi.sv | 178 +++++++++++++++++
 tb/tb_mem_responder_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_multi.sv
// Memory-side responder for the multicycle datapath: WAIT_CYCLES wait states, then one RAM access cycle and a one-cycle oReady pulse.
// `define MEMRESP_SUBWORD_EN enables sh/sb/lh/lhu/lb/lbu; otherwise every access is a full word.
module mem_responder_multi #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic [1:0]  iWriteCase,
  input  logic [2:0]  iLoadCase,
  output logic [31:0] oRData,
  output logic        oReady,
  output logic        oBusy,
  output logic        oMisaligned
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_is_write;
  logic [31:0]         r_rdata;
  logic                r_ready;
  logic                r_busy;
  logic                r_mis;
  logic [31:0]         r_ram [0:(1<<ADDR_W)-1];

  logic                w_req;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_word;
  logic                w_misaligned;
  logic [3:0]          w_be;
  logic [31:0]         w_wlane;
  logic [31:0]         w_load;
  logic                w_ready_d;
  logic                w_busy_d;
  logic                w_mis_d;
  logic                w_rdata_ld;
  logic                w_ram_we;
  logic                w_unused;

  assign w_req  = iMemRead | iMemWrite;
  assign w_idx  = r_addr[ADDR_W+1:2];
  assign w_word = r_ram[w_idx];

`ifdef MEMRESP_SUBWORD_EN
  logic [1:0]  r_wcase;
  logic [2:0]  r_lcase;
  logic        w_is_half;
  logic        w_is_byte;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_unused  = ^iAddr[31:ADDR_W+2];
  assign w_is_half = r_is_write ? (r_wcase == 2'b01) : (r_lcase == 3'b001 || r_lcase == 3'b010);
  assign w_is_byte = r_is_write ? (r_wcase == 2'b10) : (r_lcase == 3'b011 || r_lcase == 3'b100);
  assign w_byte    = 8'(w_word >> {r_addr[1:0], 3'b000});
  assign w_half    = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_misaligned = (r_addr[1:0] != 2'b00);
    w_be         = 4'b1111;
    w_wlane      = r_wdata;
    if (w_is_byte) begin
      w_misaligned = 1'b0;
      w_be         = 4'b0001 << r_addr[1:0];
      w_wlane      = {4{r_wdata[7:0]}};
    end else if (w_is_half) begin
      w_misaligned = r_addr[0];
      w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
      w_wlane      = {2{r_wdata[15:0]}};
    end
  end

  always_comb begin
    case (r_lcase)
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = {16'h0000, w_half};
      3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h000000, w_byte};
      default: w_load = w_word;
    endcase
  end
`else
  assign w_unused     = ^{iAddr[31:ADDR_W+2], iWriteCase, iLoadCase};
  assign w_misaligned = (r_addr[1:0] != 2'b00);
  assign w_be         = 4'b1111;
  assign w_wlane      = r_wdata;
  assign w_load       = w_word;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle early and registered, so no input reaches an output combinationally.
  always_comb begin
    w_ready_d  = (r_state == S_ACCESS);
    w_busy_d   = (w_next != S_IDLE);
    w_mis_d    = (r_state == S_ACCESS) && w_misaligned;
    w_rdata_ld = (r_state == S_ACCESS) && !r_is_write && !w_misaligned;
    w_ram_we   = (r_state == S_ACCESS) && r_is_write && !w_misaligned;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_is_write <= 1'b0;
`ifdef MEMRESP_SUBWORD_EN
      r_wcase    <= 2'b00;
      r_lcase    <= 3'b000;
`endif
    end else if (r_state == S_IDLE && w_req) begin
      r_cnt      <= LP_CNT_INIT;
      r_addr     <= iAddr[ADDR_W+1:0];
      r_wdata    <= iWData;
      r_is_write <= iMemWrite;
`ifdef MEMRESP_SUBWORD_EN
      r_wcase    <= iWriteCase;
      r_lcase    <= iLoadCase;
`endif
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_rdata <= 32'h0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_ready <= w_ready_d;
      r_busy  <= w_busy_d;
      r_mis   <= w_mis_d;
      if (w_rdata_ld) r_rdata <= w_load;
    end
  end

  // RAM has no reset; contents survive iRST.
  always_ff @(posedge iCLK) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_ram[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  assign oRData      = r_rdata;
  assign oReady      = r_ready;
  assign oBusy       = r_busy;
  assign oMisaligned = r_mis;

endmodule

// File: tb/tb_mem_responder_multi.sv
// Directed bench: W=2 responder driven from a vector table plus hand sequences, and a W=0 responder for minimum latency.
module tb_mem_responder_multi;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;

  logic        rd2 = 0, wr2 = 0, rd0 = 0, wr0 = 0;
  logic [31:0] addr2 = 0, wd2 = 0, addr0 = 0, wd0 = 0;
  logic [1:0]  wc2 = 0, wc0 = 0;
  logic [2:0]  lc2 = 0, lc0 = 0;
  logic [31:0] oRData2, oRData0;
  logic        oReady2, oBusy2, oMis2, oReady0, oBusy0, oMis0;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef MEMRESP_SUBWORD_EN
  localparam logic [31:0] EXP10 = 32'hCAFEF00D;
  localparam logic [1:0]  WC0   = 2'b00;
`else
  localparam logic [31:0] EXP10 = 32'h000000AB;
  localparam logic [1:0]  WC0   = 2'b10;
`endif

  always #5 iCLK = ~iCLK;

  mem_responder_multi #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMemRead(rd2), .iMemWrite(wr2), .iAddr(addr2), .iWData(wd2),
    .iWriteCase(wc2), .iLoadCase(lc2), .oRData(oRData2), .oReady(oReady2), .oBusy(oBusy2),
    .oMisaligned(oMis2)
  );

  mem_responder_multi #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .iCLK(iCLK), .iRST(iRST), .iMemRead(rd0), .iMemWrite(wr0), .iAddr(addr0), .iWData(wd0),
    .iWriteCase(wc0), .iLoadCase(lc0), .oRData(oRData0), .oReady(oReady0), .oBusy(oBusy0),
    .oMisaligned(oMis0)
  );

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wc;
    logic [2:0]  lc;
    logic [31:0] exp_rd;
    bit          exp_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit we, input bit re, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] wc, input logic [2:0] lc);
    if (sel) begin
      wr0 = we; rd0 = re; addr0 = a; wd0 = d; wc0 = wc; lc0 = lc;
    end else begin
      wr2 = we; rd2 = re; addr2 = a; wd2 = d; wc2 = wc; lc2 = lc;
    end
  endtask

  // Called just after a negedge with the DUT idle; that cycle is cycle 0.
  task automatic do_acc(input bit sel, input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] wc, input logic [2:0] lc,
                        input bit scramble, output int lat, output logic [31:0] rd,
                        output logic mis, output bit busy_ok);
    bit rdy;
    drive(sel, we, re, a, d, wc, lc);
    lat = 0; busy_ok = 1'b1; rdy = 1'b0; rd = '0; mis = 1'b0;
    while (!rdy && lat < 40) begin
      @(negedge iCLK);
      lat++;
      if (scramble && lat == 1) drive(sel, we, 1'b1, a ^ 32'h4, ~d, 2'b10, 3'b011);
      if (!(sel ? oBusy0 : oBusy2)) busy_ok = 1'b0;
      rdy = sel ? oReady0 : oReady2;
      rd  = sel ? oRData0 : oRData2;
      mis = sel ? oMis0 : oMis2;
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    @(negedge iCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        mis;
    bit          bok;
    bit          seen;

    tbl.push_back('{1, 0, 32'h10,  32'hDEADBEEF, 2'b00, 3'b000, 32'h00000000, 0});
    tbl.push_back('{0, 1, 32'h10,  32'h0,        2'b00, 3'b000, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 32'h11,  32'h0,        2'b00, 3'b000, 32'hDEADBEEF, 1});
    tbl.push_back('{1, 0, 32'h12,  32'h11111111, 2'b00, 3'b000, 32'hDEADBEEF, 1});
    tbl.push_back('{0, 1, 32'h410, 32'h0,        2'b00, 3'b000, 32'hDEADBEEF, 0});
`ifdef MEMRESP_SUBWORD_EN
    tbl.push_back('{1, 0, 32'h13, 32'h00000080, 2'b10, 3'b000, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 32'h13, 32'h0,        2'b00, 3'b011, 32'hFFFFFF80, 0});
    tbl.push_back('{0, 1, 32'h13, 32'h0,        2'b00, 3'b100, 32'h00000080, 0});
    tbl.push_back('{0, 1, 32'h10, 32'h0,        2'b00, 3'b000, 32'h80ADBEEF, 0});
    tbl.push_back('{1, 0, 32'h12, 32'h00001234, 2'b01, 3'b000, 32'h80ADBEEF, 0});
    tbl.push_back('{0, 1, 32'h12, 32'h0,        2'b00, 3'b001, 32'h00001234, 0});
    tbl.push_back('{0, 1, 32'h11, 32'h0,        2'b00, 3'b001, 32'h00001234, 1});
    tbl.push_back('{0, 1, 32'h10, 32'h0,        2'b00, 3'b000, 32'h1234BEEF, 0});
    tbl.push_back('{1, 0, 32'h10, 32'h00008001, 2'b01, 3'b000, 32'h1234BEEF, 0});
    tbl.push_back('{0, 1, 32'h10, 32'h0,        2'b00, 3'b001, 32'hFFFF8001, 0});
    tbl.push_back('{0, 1, 32'h12, 32'h0,        2'b00, 3'b010, 32'h00001234, 0});
    tbl.push_back('{0, 1, 32'h10, 32'h0,        2'b00, 3'b111, 32'h12348001, 0});
    tbl.push_back('{1, 0, 32'h10, 32'hCAFEF00D, 2'b11, 3'b000, 32'h12348001, 0});
    tbl.push_back('{0, 1, 32'h11, 32'h0,        2'b00, 3'b011, 32'hFFFFFFF0, 0});
    tbl.push_back('{0, 1, 32'h12, 32'h0,        2'b00, 3'b100, 32'h000000FE, 0});
    tbl.push_back('{1, 0, 32'h13, 32'h0000FFFF, 2'b01, 3'b000, 32'h000000FE, 1});
    tbl.push_back('{0, 1, 32'h10, 32'h0,        2'b00, 3'b000, 32'hCAFEF00D, 0});
`else
    tbl.push_back('{1, 0, 32'h10, 32'h000000AB, 2'b10, 3'b000, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 1, 32'h10, 32'h0,        2'b00, 3'b011, 32'h000000AB, 0});
    tbl.push_back('{0, 1, 32'h13, 32'h0,        2'b00, 3'b011, 32'h000000AB, 1});
    tbl.push_back('{1, 0, 32'h12, 32'h00000001, 2'b01, 3'b000, 32'h000000AB, 1});
    tbl.push_back('{0, 1, 32'h10, 32'h0,        2'b00, 3'b000, 32'h000000AB, 0});
`endif

    repeat (2) @(negedge iCLK);
    chk("reset_rdata", oRData2, 32'h0);
    chk("reset_ready", {31'h0, oReady2}, 32'h0);
    chk("reset_busy",  {31'h0, oBusy2}, 32'h0);
    chk("reset_mis",   {31'h0, oMis2}, 32'h0);
    iRST = 1'b0;
    @(negedge iCLK);

    foreach (tbl[i]) begin
      do_acc(1'b0, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].wc, tbl[i].lc,
             1'b0, lat, rd, mis, bok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_mis", i), {31'h0, mis}, {31'h0, tbl[i].exp_mis});
      chk($sformatf("vec%0d_busy", i), {31'h0, bok}, 32'h1);
    end

    // Both strobes: write wins, oRData keeps the previous read value.
    do_acc(1'b0, 1'b1, 1'b1, 32'h20, 32'h55, 2'b00, 3'b000, 1'b0, lat, rd, mis, bok);
    chk("both_latency", 32'(lat), 32'd4);
    chk("both_rdata_kept", rd, EXP10);
    do_acc(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 2'b00, 3'b000, 1'b0, lat, rd, mis, bok);
    chk("both_write_won", rd, 32'h00000055);

    // Inputs changed after acceptance must be ignored.
    do_acc(1'b0, 1'b1, 1'b0, 32'h30, 32'hA5A5A5A5, 2'b00, 3'b000, 1'b1, lat, rd, mis, bok);
    chk("scramble_latency", 32'(lat), 32'd4);
    chk("scramble_mis", {31'h0, mis}, 32'h0);
    do_acc(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 2'b00, 3'b000, 1'b0, lat, rd, mis, bok);
    chk("scramble_rdata", rd, 32'hA5A5A5A5);

    // Reset during WAIT of a store.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 2'b00, 3'b000);
    @(negedge iCLK);
    chk("rst_busy_in_wait", {31'h0, oBusy2}, 32'h1);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("rst_busy_after", {31'h0, oBusy2}, 32'h0);
    chk("rst_ready_after", {31'h0, oReady2}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    iRST = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge iCLK);
      if (oReady2) seen = 1'b1;
    end
    chk("rst_no_ready", {31'h0, seen}, 32'h0);
    do_acc(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 3'b000, 1'b0, lat, rd, mis, bok);
    chk("rst_ram_kept", rd, EXP10);

    // Zero wait states: two-cycle latency.
    do_acc(1'b1, 1'b1, 1'b0, 32'h10, 32'h12345678, WC0, 3'b000, 1'b0, lat, rd, mis, bok);
    chk("w0_wr_latency", 32'(lat), 32'd2);
    chk("w0_wr_mis", {31'h0, mis}, 32'h0);
    chk("w0_wr_busy", {31'h0, bok}, 32'h1);
    do_acc(1'b1, 1'b0, 1'b1, 32'h12, 32'h0, 2'b00, 3'b000, 1'b0, lat, rd, mis, bok);
    chk("w0_mis_latency", 32'(lat), 32'd2);
    chk("w0_mis_flag", {31'h0, mis}, 32'h1);
    chk("w0_mis_rdata", rd, 32'h0);
    do_acc(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 3'b000, 1'b0, lat, rd, mis, bok);
    chk("w0_rd_rdata", rd, 32'h12345678);
    chk("w0_rd_latency", 32'(lat), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
